// File: rtl/unified_mem_seq.sv
// unified_mem_seq: sequences instruction fetch and data load/store over one shared req/ack memory port.
// Ports:
//   clk, reset (async, active-low)        clock and reset
//   PC, ALUResult, WriteData              fetch address, data address and store data from the datapath
//   MemRead, MemWrite                     decoded load/store for the current Instr
//   Instr, ReadData                       registered fetched instruction and load data
//   Stall                                 1 = core holds; 0 = commit cycle
//   mem_req, mem_we, mem_addr, mem_wdata  memory request, word-aligned
//   mem_rdata, mem_ack                    memory response
//   instr_count                           retired-instruction count, wraps
//   mem_fault                             sticky timeout fault
// Optional feature: define MEM_TIMEOUT_EN for a per-transfer wait limit of TIMEOUT_CYCLES and a halt state.
module unified_mem_seq #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      PC,
    input  logic [31:0]      ALUResult,
    input  logic [31:0]      WriteData,
    input  logic             MemRead,
    input  logic             MemWrite,
    output logic [31:0]      Instr,
    output logic [31:0]      ReadData,
    output logic             Stall,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_ack,
    output logic [CNT_W-1:0] instr_count,
    output logic             mem_fault
);
    localparam logic [2:0] S_RST   = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_WB    = 3'd4;
    logic [2:0]       state_q, state_d;
    logic [31:0]      instr_q, instr_d, rdata_q, rdata_d, addr_q, addr_d, wdata_q, wdata_d;
    logic             we_q, we_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req, ack, mem_op;
    // Only acks that land on an outstanding request count; this also discards stale post-reset acks.
    assign req    = (state_q == S_FETCH) || (state_q == S_DATA);
    assign ack    = req && mem_ack;
    assign mem_op = MemRead || MemWrite;
`ifdef MEM_TIMEOUT_EN
    localparam logic [2:0] S_HALT = 3'd5;
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              fault_q, fault_d;
    assign mem_fault = fault_q;
`else
    assign mem_fault = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_RST:   state_d = S_FETCH;
            S_FETCH: if (ack) begin
                instr_d = mem_rdata;
                state_d = S_EXEC;
            end
            S_EXEC: if (mem_op) begin
                addr_d  = ALUResult;
                wdata_d = WriteData;
                we_d    = MemWrite;
                state_d = S_DATA;
            end else begin
                cnt_d   = cnt_q + 1'b1;
                state_d = S_FETCH;
            end
            S_DATA: if (ack) begin
                rdata_d = we_q ? rdata_q : mem_rdata;
                state_d = S_WB;
            end
            S_WB: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = S_FETCH;
            end
`ifdef MEM_TIMEOUT_EN
            S_HALT:  state_d = S_HALT;
`endif
            default: state_d = S_RST;
        endcase
`ifdef MEM_TIMEOUT_EN
        // Every request state is entered from a non-request state, so the counter is already clear on entry.
        wait_d  = (req && !mem_ack) ? wait_q + 1'b1 : '0;
        fault_d = fault_q;
        if (req && !mem_ack && wait_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
            state_d = S_HALT;
            fault_d = 1'b1;
        end
`endif
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_RST;
            instr_q <= '0;
            rdata_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
`ifdef MEM_TIMEOUT_EN
            wait_q  <= '0;
            fault_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
`ifdef MEM_TIMEOUT_EN
            wait_q  <= wait_d;
            fault_q <= fault_d;
`endif
        end
    end
    // Stall depends on MemRead/MemWrite only in S_EXEC, where Instr is already stable.
    assign Stall       = !(((state_q == S_EXEC) && !mem_op) || (state_q == S_WB));
    assign mem_req     = req;
    assign mem_we      = (state_q == S_DATA) && we_q;
    assign mem_addr    = (state_q == S_FETCH) ? (PC & 32'hFFFF_FFFC) :
                         (state_q == S_DATA)  ? (addr_q & 32'hFFFF_FFFC) : 32'h0;
    assign mem_wdata   = (state_q == S_DATA) ? wdata_q : 32'h0;
    assign Instr       = instr_q;
    assign ReadData    = rdata_q;
    assign instr_count = cnt_q;
endmodule

// File: tb/tb_unified_mem_seq.sv
// tb_unified_mem_seq: table-driven cycle-by-cycle check of unified_mem_seq plus an async-reset sequence.
module tb_unified_mem_seq;
    logic        clk, reset;
    logic [31:0] PC, ALUResult, WriteData, mem_rdata;
    logic        MemRead, MemWrite, mem_ack;
    logic [31:0] Instr, ReadData, mem_addr, mem_wdata;
    logic        Stall, mem_req, mem_we, mem_fault;
    logic [31:0] instr_count;
    int          checks = 0;
    int          failures = 0;

    unified_mem_seq #(.TIMEOUT_CYCLES(255), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .PC(PC), .ALUResult(ALUResult), .WriteData(WriteData),
        .MemRead(MemRead), .MemWrite(MemWrite), .Instr(Instr), .ReadData(ReadData),
        .Stall(Stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .instr_count(instr_count), .mem_fault(mem_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, alu, wd;
        logic        mr, mw;
        logic [31:0] rdata;
        logic        ack;
        logic        stall, req, we;
        logic [31:0] addr, wdata, instr, rd, cnt;
    } vec_t;
    vec_t vq[$];

    task automatic t(input logic [31:0] pc, alu, wd, input logic mr, mw, input logic [31:0] rdata,
                     input logic ack, input logic stall, req, we, input logic [31:0] addr, wdata, instr, rd, cnt);
        vec_t v;
        v = '{pc, alu, wd, mr, mw, rdata, ack, stall, req, we, addr, wdata, instr, rd, cnt};
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        reset = 1'b0; PC = 0; ALUResult = 0; WriteData = 0; MemRead = 0; MemWrite = 0;
        mem_rdata = 0; mem_ack = 0;
        //  pc      alu     wd          mr mw rdata        ack | st rq we addr  wdata        instr        rd           cnt
        t(32'h0,  32'h0,   32'h0,       0, 0, 32'h0,        1,  1, 0, 0, 32'h0,  32'h0,       32'h0,       32'h0,       0);
        t(32'h0,  32'h0,   32'h0,       0, 0, 32'hE2811001, 1,  1, 1, 0, 32'h0,  32'h0,       32'h0,       32'h0,       0);
        t(32'h0,  32'h0,   32'h0,       0, 0, 32'h0,        0,  0, 0, 0, 32'h0,  32'h0,       32'hE2811001, 32'h0,      0);
        t(32'h4,  32'h0,   32'h0,       0, 0, 32'hE5910000, 1,  1, 1, 0, 32'h4,  32'h0,       32'hE2811001, 32'h0,      1);
        t(32'h4,  32'h103, 32'hAAAA5555, 1, 0, 32'h0,       0,  1, 0, 0, 32'h0,  32'h0,       32'hE5910000, 32'h0,      1);
        t(32'h4,  32'hFFF, 32'h0,       1, 0, 32'h0,        0,  1, 1, 0, 32'h100, 32'h0,      32'hE5910000, 32'h0,      1);
        t(32'h4,  32'hFFF, 32'h0,       1, 0, 32'h0,        0,  1, 1, 0, 32'h100, 32'h0,      32'hE5910000, 32'h0,      1);
        t(32'h4,  32'hFFF, 32'h0,       1, 0, 32'hDEADBEEF, 1,  1, 1, 0, 32'h100, 32'h0,      32'hE5910000, 32'h0,      1);
        t(32'h4,  32'h0,   32'h0,       0, 0, 32'h11111111, 1,  0, 0, 0, 32'h0,  32'h0,       32'hE5910000, 32'hDEADBEEF, 1);
        t(32'h8,  32'h0,   32'h0,       0, 0, 32'hE5812000, 1,  1, 1, 0, 32'h8,  32'h0,       32'hE5910000, 32'hDEADBEEF, 2);
        t(32'h8,  32'h200, 32'h12345678, 0, 1, 32'h0,       0,  1, 0, 0, 32'h0,  32'h0,       32'hE5812000, 32'hDEADBEEF, 2);
        t(32'h8,  32'h300, 32'h0,       0, 1, 32'h0,        0,  1, 1, 1, 32'h200, 32'h12345678, 32'hE5812000, 32'hDEADBEEF, 2);
        t(32'h8,  32'h300, 32'h0,       0, 1, 32'h0,        0,  1, 1, 1, 32'h200, 32'h12345678, 32'hE5812000, 32'hDEADBEEF, 2);
        t(32'h8,  32'h300, 32'h0,       0, 1, 32'h0,        0,  1, 1, 1, 32'h200, 32'h12345678, 32'hE5812000, 32'hDEADBEEF, 2);
        t(32'h8,  32'h300, 32'h0,       0, 1, 32'hCAFEF00D, 1,  1, 1, 1, 32'h200, 32'h12345678, 32'hE5812000, 32'hDEADBEEF, 2);
        t(32'h8,  32'h0,   32'h0,       0, 0, 32'h0,        0,  0, 0, 0, 32'h0,  32'h0,       32'hE5812000, 32'hDEADBEEF, 2);
        t(32'hC,  32'h0,   32'h0,       0, 0, 32'hE5912000, 1,  1, 1, 0, 32'hC,  32'h0,       32'hE5812000, 32'hDEADBEEF, 3);
        t(32'hC,  32'h41,  32'h0BADF00D, 1, 1, 32'h0,       0,  1, 0, 0, 32'h0,  32'h0,       32'hE5912000, 32'hDEADBEEF, 3);
        t(32'hC,  32'h0,   32'h0,       1, 1, 32'h99999999, 1,  1, 1, 1, 32'h40, 32'h0BADF00D, 32'hE5912000, 32'hDEADBEEF, 3);
        t(32'hC,  32'h0,   32'h0,       0, 0, 32'h0,        0,  0, 0, 0, 32'h0,  32'h0,       32'hE5912000, 32'hDEADBEEF, 3);
        t(32'h10, 32'h0,   32'h0,       0, 0, 32'h0,        0,  1, 1, 0, 32'h10, 32'h0,       32'hE5912000, 32'hDEADBEEF, 4);
        t(32'h10, 32'h0,   32'h0,       0, 0, 32'h0,        0,  1, 1, 0, 32'h10, 32'h0,       32'hE5912000, 32'hDEADBEEF, 4);
        t(32'h10, 32'h0,   32'h0,       0, 0, 32'hE1A00000, 1,  1, 1, 0, 32'h10, 32'h0,       32'hE5912000, 32'hDEADBEEF, 4);
        t(32'h10, 32'h0,   32'h0,       0, 0, 32'h0,        0,  0, 0, 0, 32'h0,  32'h0,       32'hE1A00000, 32'hDEADBEEF, 4);
        t(32'h14, 32'h0,   32'h0,       0, 0, 32'h0,        0,  1, 1, 0, 32'h14, 32'h0,       32'hE1A00000, 32'hDEADBEEF, 5);
        repeat (2) @(negedge clk);
        chk("rst_req", {31'b0, mem_req}, 0);
        chk("rst_we", {31'b0, mem_we}, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_stall", {31'b0, Stall}, 1);
        chk("rst_instr", Instr, 0);
        chk("rst_rd", ReadData, 0);
        chk("rst_cnt", instr_count, 0);
        chk("rst_fault", {31'b0, mem_fault}, 0);
        reset = 1'b1;
        for (int i = 0; i < vq.size(); i++) begin
            PC = vq[i].pc; ALUResult = vq[i].alu; WriteData = vq[i].wd;
            MemRead = vq[i].mr; MemWrite = vq[i].mw; mem_rdata = vq[i].rdata; mem_ack = vq[i].ack;
            #1;
            chk($sformatf("v%0d_stall", i), {31'b0, Stall}, {31'b0, vq[i].stall});
            chk($sformatf("v%0d_req", i), {31'b0, mem_req}, {31'b0, vq[i].req});
            if (vq[i].req) begin
                chk($sformatf("v%0d_we", i), {31'b0, mem_we}, {31'b0, vq[i].we});
                chk($sformatf("v%0d_addr", i), mem_addr, vq[i].addr);
            end
            if (vq[i].we) chk($sformatf("v%0d_wdata", i), mem_wdata, vq[i].wdata);
            chk($sformatf("v%0d_instr", i), Instr, vq[i].instr);
            chk($sformatf("v%0d_rd", i), ReadData, vq[i].rd);
            chk($sformatf("v%0d_cnt", i), instr_count, vq[i].cnt);
            chk($sformatf("v%0d_fault", i), {31'b0, mem_fault}, 0);
            @(negedge clk);
        end
        // Load issued, then reset asserted while its data access is waiting.
        PC = 32'h14; mem_ack = 1'b1; mem_rdata = 32'hE5910000;
        @(negedge clk);
        mem_ack = 1'b0; MemRead = 1'b1; ALUResult = 32'h80;
        #1 chk("mr_exec_stall", {31'b0, Stall}, 1);
        @(negedge clk);
        #1 chk("mr_data_req", {31'b0, mem_req}, 1);
        chk("mr_data_addr", mem_addr, 32'h80);
        #2 reset = 1'b0;
        #1 chk("ar_req", {31'b0, mem_req}, 0);
        chk("ar_stall", {31'b0, Stall}, 1);
        chk("ar_addr", mem_addr, 0);
        chk("ar_we", {31'b0, mem_we}, 0);
        chk("ar_instr", Instr, 0);
        chk("ar_rd", ReadData, 32'h0);
        chk("ar_cnt", instr_count, 0);
        @(negedge clk);
        reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF; PC = 32'h20; MemRead = 1'b0;
        #1 chk("pr_req", {31'b0, mem_req}, 0);
        chk("pr_stall", {31'b0, Stall}, 1);
        @(negedge clk);
        mem_ack = 1'b0;
        #1 chk("pr_fetch_req", {31'b0, mem_req}, 1);
        chk("pr_fetch_addr", mem_addr, 32'h20);
        chk("pr_instr", Instr, 0);
        chk("pr_cnt", instr_count, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
